// File: rtl/mult_div_unit.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// One shift-add or restoring-divide step per cycle; XLEN cycles per operation.
module mult_div_unit #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs_data,
  input  logic [XLEN-1:0] rt_data,
  input  logic            hi_we,
  input  logic            lo_we,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic            busy,
  output logic            done
);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                is_div_q;
  logic                quo_sign_q;
  logic                rem_sign_q;
  logic                div0_q;
  logic [XLEN-1:0]     opnd_q;
  logic [2*XLEN-1:0]   acc_q;
  logic [XLEN-1:0]     hi_q;
  logic [XLEN-1:0]     lo_q;
  logic                busy_q;
  logic                done_q;

  logic                signed_op;
  logic [XLEN-1:0]     rs_mag;
  logic [XLEN-1:0]     rt_mag;
  logic [XLEN:0]       mul_sum;
  logic [XLEN:0]       rem_sh;
  logic [XLEN:0]       rem_diff;
  logic [2*XLEN-1:0]   acc_step;
  logic [2*XLEN-1:0]   prod;
  logic [XLEN-1:0]     res_hi;
  logic [XLEN-1:0]     res_lo;
  logic                last_iter;

  always_comb begin
    signed_op = ~op[0];
    rs_mag    = (signed_op && rs_data[XLEN-1]) ? -rs_data : rs_data;
    rt_mag    = (signed_op && rt_data[XLEN-1]) ? -rt_data : rt_data;
  end

  // acc_q holds {partial product, multiplier} or {remainder, dividend/quotient}.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    rem_sh   = acc_q[2*XLEN-1:XLEN-1];
    rem_diff = rem_sh - {1'b0, opnd_q};
    if (!is_div_q) begin
      acc_step = {mul_sum, acc_q[XLEN-1:1]};
    end else if (!rem_diff[XLEN]) begin
      acc_step = {rem_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end else begin
      acc_step = {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    end
  end

  always_comb begin
    prod = quo_sign_q ? -acc_step : acc_step;
    if (is_div_q) begin
      // Divide by zero: quotient all ones; remainder path already yields the dividend.
      if (div0_q) begin
        res_lo = '1;
      end else begin
        res_lo = quo_sign_q ? -acc_step[XLEN-1:0] : acc_step[XLEN-1:0];
      end
      res_hi = rem_sign_q ? -acc_step[2*XLEN-1:XLEN] : acc_step[2*XLEN-1:XLEN];
    end else begin
      res_lo = prod[XLEN-1:0];
      res_hi = prod[2*XLEN-1:XLEN];
    end
  end

  assign last_iter = (cnt_q == CNT_W'(XLEN - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      is_div_q   <= 1'b0;
      quo_sign_q <= 1'b0;
      rem_sign_q <= 1'b0;
      div0_q     <= 1'b0;
      opnd_q     <= '0;
      acc_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          done_q <= 1'b0;
          if (hi_we) hi_q <= wdata;
          if (lo_we) lo_q <= wdata;
          if (start) begin
            is_div_q   <= op[1];
            quo_sign_q <= signed_op & (rs_data[XLEN-1] ^ rt_data[XLEN-1]);
            rem_sign_q <= signed_op & rs_data[XLEN-1];
            div0_q     <= (rt_data == '0);
            opnd_q     <= op[1] ? rt_mag : rs_mag;
            acc_q      <= {{XLEN{1'b0}}, (op[1] ? rs_mag : rt_mag)};
            cnt_q      <= '0;
            busy_q     <= 1'b1;
            state_q    <= StCalc;
          end else begin
            state_q <= StIdle;
          end
        end
        StCalc: begin
          acc_q <= acc_step;
          cnt_q <= cnt_q + CNT_W'(1);
          if (last_iter) begin
            hi_q    <= res_hi;
            lo_q    <= res_lo;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StDone;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative 32-bit multiply/divide unit in the EX stage, directly downstream of the register file.
- Consumes the rs/rt values the register file reads out and executes MULT, MULTU, DIV and DIVU into architectural HI/LO registers.
- Supports MTHI/MTLO writes and exposes HI/LO for MFHI/MFLO.
- Exposes busy/done so the hazard unit can stall dependent instructions.

Parameters:
- XLEN, 32, operand and HI/LO width.
- CNT_W, 6, iteration counter width; must hold the value XLEN.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a new operation; sampled only when idle.
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- rs_data  input  XLEN  multiplicand / dividend (register file read_data1).
- rt_data  input  XLEN  multiplier / divisor (register file read_data2).
- hi_we  input  1  MTHI write enable.
- lo_we  input  1  MTLO write enable.
- wdata  input  XLEN  MTHI/MTLO data.
- hi  output  XLEN  HI register.
- lo  output  XLEN  LO register.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse; HI/LO hold the new result.

Behaviour:
- Reset: state IDLE, hi = 0, lo = 0, busy = 0, done = 0, counter = 0. Reset mid-operation aborts it; HI/LO are zeroed, not left partially updated.
- FSM states: IDLE, CALC, DONE.
- IDLE or DONE with start = 1:
  - Latch op and operands.
  - Signed ops (MULT, DIV): convert operands to magnitudes; record sign_q = rs[31]^rt[31] and sign_r = rs[31].
  - Clear counter; go to CALC.
- DONE with start = 0 goes to IDLE.
- CALC: one iteration per cycle for exactly XLEN cycles.
  - Multiply uses shift-add over a 2·XLEN product.
  - Divide uses restoring division: shift remainder, trial-subtract divisor, set quotient bit.
  - On the cycle counter = XLEN-1, go to DONE and write the results on that edge:
    - Multiply: HI = product[63:32], LO = product[31:0]. MULT negates the 64-bit product if sign_q = 1.
    - Divide: LO = quotient, HI = remainder. DIV negates quotient if sign_q = 1 and remainder if sign_r = 1.
- Latency: start sampled at edge E0. busy = 1 after E0 up to E32. HI/LO valid and done = 1 after E32, for one cycle. busy = 0 in DONE.
- A new start is accepted in DONE, giving back-to-back operations with no idle cycle.
- busy = 1 exactly in CALC; done = 1 exactly in DONE.
- start while in CALC is ignored: no restart, no queueing.
- hi_we/lo_we:
  - In IDLE/DONE, write wdata into HI/LO on that edge.
  - In CALC they are ignored; the hazard unit guarantees stalls.
  - Simultaneous start and hi_we/lo_we in IDLE: the write takes effect, then the result overwrites it at completion.
- Divide by zero: full latency is still spent. LO = 0xFFFFFFFF, HI = rs_data (original value), for both DIV and DIVU. No exception.
- Signed overflow, DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0x00000000.
- Operands are sampled only at start; later changes on rs_data/rt_data have no effect.
- hi/lo are driven from registers; outputs are combinationally independent of the inputs.

Test Plan:
- Reset, then MULTU rs = 0xFFFFFFFF, rt = 0xFFFFFFFF -> busy high 32 cycles; done at cycle 33 with HI = 0xFFFFFFFE, LO = 0x00000001.
- MULT rs = 0xFFFFFFFD (-3), rt = 7 -> HI = 0xFFFFFFFF, LO = 0xFFFFFFEB. Then a back-to-back DIV rs = 0xFFFFFFF9 (-7), rt = 2 started in the DONE cycle -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
- DIVU rs = 100, rt = 0 -> LO = 0xFFFFFFFF, HI = 0x00000064 at cycle 33. DIV 0x80000000 / 0xFFFFFFFF -> LO = 0x80000000, HI = 0.
- Start DIVU 1000/7; pulse start with other operands at cycle 5 and hi_we at cycle 10 -> both ignored; result LO = 142, HI = 6.
- Start MULTU 5×6; assert reset at cycle 10 -> next cycle busy = 0, done = 0, HI = LO = 0; no done pulse afterwards.
- In IDLE: hi_we with wdata = 0x12345678, then lo_we with wdata = 0xCAFEBABE -> HI/LO read back those values one cycle after each write.
